// File: rtl/pipe_interlock.sv
// Pipeline interlock for the DPCPU3 five-stage pipeline: load-use and mul/div
// (HI/LO) hazard detection, branch flush, and a stall-cycle performance counter.
module pipe_interlock #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_md,
    input  logic             id_use_hilo,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [4:0]       ex_rd,
    input  logic             ex_br_taken,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] CNT_INIT = 8'(MD_LAT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              md_busy_q, md_busy_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic lu;
    logic md_hz;

    always_comb begin
        lu = ex_wreg && ex_m2reg && (ex_rd != 5'd0) &&
             ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
        md_hz = (state_q == BUSY) && (id_is_md || id_use_hilo);
    end

    // Hazard outputs and FSM next state; a taken branch overrides all stalls,
    // and the start pulse is never issued in a cycle that stalls.
    always_comb begin
        stall       = 1'b0;
        bubble      = 1'b0;
        flush       = 1'b0;
        md_start    = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;

        if (!clr) begin
            if (ex_br_taken) begin
                flush  = 1'b1;
                bubble = 1'b1;
            end else begin
                stall  = lu || md_hz;
                bubble = lu || md_hz;
            end
        end

        case (state_q)
            IDLE: begin
                if (!clr && id_is_md && !lu && !ex_br_taken) begin
                    md_start = 1'b1;
                    cnt_d    = CNT_INIT;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        md_busy_d   = (state_d == BUSY);
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            md_busy_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_busy_q   <= md_busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign md_busy   = md_busy_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_interlock.sv
// Directed bench for pipe_interlock with MD_LAT=4 and a 4-bit stall counter.
module tb_pipe_interlock;

    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             clr;
    logic [4:0]       id_rs, id_rt, ex_rd;
    logic             id_use_rs, id_use_rt, id_is_md, id_use_hilo;
    logic             ex_wreg, ex_m2reg, ex_br_taken;
    logic             stall, bubble, flush, md_start, md_busy;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_interlock #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_md(id_is_md), .id_use_hilo(id_use_hilo),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
        .stall(stall), .bubble(bubble), .flush(flush), .md_start(md_start),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_is_md = 1'b0; id_use_hilo = 1'b0;
        ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_br_taken = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd);
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rd = rd;
        id_use_rt = 1'b1; id_rt = 5'd5;
    endtask

    initial begin
        idle_inputs();
        clr = 1'b1;
        // Reset: combinational outputs forced low even with hazards present
        id_is_md = 1'b1;
        load_use(5'd5);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_md_start", md_start, 0);
        tick();
        chk("rst_busy", md_busy, 0);
        chk("rst_cnt", stall_cnt, 0);

        // Load-use stall, then ex_rd=0 does not stall
        clr = 1'b0;
        idle_inputs();
        load_use(5'd5);
        #1;
        chk("lu_stall", stall, 1);
        chk("lu_bubble", bubble, 1);
        chk("lu_flush", flush, 0);
        tick();
        chk("lu_cnt", stall_cnt, 1);
        ex_rd = 5'd0;
        #1;
        chk("lu_r0_stall", stall, 0);
        tick();
        chk("lu_r0_cnt", stall_cnt, 1);

        // Mul/div start at T then mflo stalls T+1..T+4
        idle_inputs();
        id_is_md = 1'b1;
        #1;
        chk("md_start_T", md_start, 1);
        chk("md_stall_T", stall, 0);
        tick();
        id_is_md = 1'b0; id_use_hilo = 1'b1;
        for (int i = 1; i <= MD_LAT; i++) begin
            #1;
            chk($sformatf("mflo_stall_T%0d", i), stall, 1);
            chk($sformatf("mflo_busy_T%0d", i), md_busy, 1);
            chk($sformatf("mflo_start_T%0d", i), md_start, 0);
            tick();
        end
        #1;
        chk("mflo_busy_T5", md_busy, 0);
        chk("mflo_stall_T5", stall, 0);
        chk("mflo_cnt", stall_cnt, 5);

        // Start again; independent instr flows, back-to-back md waits
        idle_inputs();
        id_is_md = 1'b1;
        #1;
        chk("md2_start", md_start, 1);
        tick();
        id_is_md = 1'b0; id_use_rs = 1'b1; id_rs = 5'd3;
        #1;
        chk("indep_stall", stall, 0);
        chk("indep_busy", md_busy, 1);
        tick();
        idle_inputs();
        id_is_md = 1'b1;
        for (int i = 2; i <= MD_LAT; i++) begin
            #1;
            chk($sformatf("b2b_stall_T%0d", i), stall, 1);
            chk($sformatf("b2b_start_T%0d", i), md_start, 0);
            tick();
        end
        #1;
        chk("b2b_busy_T5", md_busy, 0);
        chk("b2b_start_T5", md_start, 1);
        chk("b2b_stall_T5", stall, 0);
        chk("b2b_cnt", stall_cnt, 8);
        tick();
        id_is_md = 1'b0;
        #1;
        chk("b2b_busy_T6", md_busy, 1);
        tick();

        // Reset mid-BUSY (second cycle of the new operation)
        clr = 1'b1;
        id_use_hilo = 1'b1;
        #1;
        chk("clr_busy_stall", stall, 0);
        tick();
        chk("clr_busy_after", md_busy, 0);
        chk("clr_cnt_after", stall_cnt, 0);
        clr = 1'b0;
        idle_inputs();
        id_is_md = 1'b1;
        #1;
        chk("post_clr_start", md_start, 1);
        tick();
        idle_inputs();
        #1;
        chk("post_clr_busy", md_busy, 1);

        // Branch priority from IDLE
        clr = 1'b1;
        tick();
        clr = 1'b0;
        load_use(5'd5);
        id_is_md = 1'b1;
        ex_br_taken = 1'b1;
        #1;
        chk("br_flush", flush, 1);
        chk("br_bubble", bubble, 1);
        chk("br_stall", stall, 0);
        chk("br_start", md_start, 0);
        tick();
        chk("br_idle", md_busy, 0);
        chk("br_cnt", stall_cnt, 0);

        // Counter wrap: 17 stall cycles on a 4-bit counter
        idle_inputs();
        load_use(5'd5);
        for (int i = 0; i < 16; i++) tick();
        chk("wrap_16", stall_cnt, 0);
        tick();
        chk("wrap_17", stall_cnt, 1);

        // Load-use and HI/LO hazard together count once
        idle_inputs();
        id_is_md = 1'b1;
        tick();
        idle_inputs();
        load_use(5'd5);
        id_use_hilo = 1'b1;
        #1;
        chk("both_stall", stall, 1);
        tick();
        chk("both_cnt", stall_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
